// File: rtl/act_skew_feeder.sv
// act_skew_feeder
//   Buffers one tile of N input vectors (N lanes x DW bits) from a valid/ready
//   source, then streams the tile into an NxN systolic array with diagonal
//   skew: lane i is delayed by i cycles, so the array sees wavefront-aligned
//   data. A tile streams over 2N-1 consecutive clocks with no backpressure.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream vector valid
//   in_ready   feeder accepts a vector this cycle (low only while streaming)
//   in_data    input vector, lane i at [i*DW +: DW]
//   out_data   skewed lane data to the array, lane i at [i*DW +: DW]
//   out_valid  per-lane element valid
//   busy       high while loading or streaming a tile
//   tile_done  one-cycle pulse alongside the final skewed element of a tile
module act_skew_feeder #(
  parameter int N  = 8,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  output logic [N*DW-1:0] out_data,
  output logic [N-1:0]    out_valid,
  output logic            busy,
  output logic            tile_done
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (N > 1) ? $clog2(2 * N - 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [SW-1:0]   step_q, step_d;
  logic [N*DW-1:0] out_data_q, out_data_d;
  logic [N-1:0]    out_valid_q, out_valid_d;
  logic            tile_done_q, tile_done_d;

  // Tile storage: one packed row per accepted vector. No reset needed, the
  // contents are only read after a full tile has been written.
  logic [N*DW-1:0] tile_q [N];

  logic [N*DW-1:0] lane_data;
  logic [N-1:0]    lane_vld;
  logic            accept;

  assign in_ready  = (state_q != STREAM);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid & in_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign tile_done = tile_done_q;

  // Lane i at step t reads row t-i. The subtraction carries one extra bit so
  // its MSB flags t < i (lane not started yet); rel >= N means lane finished.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [SW:0] rel_w;
    assign rel_w        = {1'b0, step_q} - (SW + 1)'(gi);
    assign lane_vld[gi] = !rel_w[SW] && (rel_w < (SW + 1)'(N));
    assign lane_data[gi*DW +: DW] =
      lane_vld[gi] ? tile_q[rel_w[RW-1:0]][gi*DW +: DW] : '0;
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    step_d      = step_q;
    out_data_d  = '0;
    out_valid_d = '0;
    tile_done_d = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (row_q == RW'(N - 1)) begin
            state_d = STREAM;
            row_d   = '0;
            step_d  = '0;
          end else begin
            state_d = LOAD;
            row_d   = row_q + RW'(1);
          end
        end
      end
      STREAM: begin
        out_data_d  = lane_data;
        out_valid_d = lane_vld;
        if (step_q == SW'(2 * N - 2)) begin
          tile_done_d = 1'b1;
          state_d     = IDLE;
          step_d      = '0;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      step_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      step_q      <= step_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      tile_done_q <= tile_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tile_q[row_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// tb_act_skew_feeder
//   Drives act_skew_feeder (N=8, DW=8) with directed and randomized tiles and
//   checks every cycle against a schedule-based model: once the 8th vector of
//   a tile is accepted at edge c, the outputs after edge c+1+t show lane i
//   holding row t-i of that tile, and the source is stalled until edge c+15.
module tb_act_skew_feeder;
  localparam int N  = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic            busy;
  logic            tile_done;

  act_skew_feeder #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .tile_done (tile_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              k = 0;
  int              c_last = -100;
  bit              have_s = 0;
  bit              in_s;
  int              nrows = 0;
  int              t;
  logic [63:0]     ld [N];
  logic [63:0]     st [N];
  logic [63:0]     e_data = '0;
  logic [7:0]      e_vld = '0;
  bit              e_done = 0, e_rdy = 1, e_busy = 0;
  logic [7:0]      prev_vld = '0;
  int              dones[$];
  int              starts[$];
  logic [7:0]      d_l7[$];
  logic [63:0]     d_data[$];
  logic [7:0]      ov_log[$];
  bit              log_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      have_s = 0;
      nrows  = 0;
      e_data = '0;
      e_vld  = '0;
      e_done = 0;
      e_rdy  = 1;
      e_busy = 0;
    end else begin
      k++;
      in_s   = have_s && (k > c_last) && (k <= c_last + 15);
      e_data = '0;
      e_vld  = '0;
      e_done = 0;
      if (in_s) begin
        t = k - c_last - 1;
        for (int i = 0; i < N; i++) begin
          if (t >= i && t < i + N) begin
            e_vld[i] = 1'b1;
            e_data[i*DW +: DW] = st[t-i][i*DW +: DW];
          end
        end
        e_done = (k == c_last + 15);
      end
      if (in_valid && !in_s) begin
        ld[nrows] = in_data;
        nrows++;
        if (nrows == N) begin
          st     = ld;
          c_last = k;
          have_s = 1;
          nrows  = 0;
        end
      end
      e_rdy  = !(have_s && k >= c_last && k < c_last + 15);
      e_busy = (nrows > 0) || !e_rdy;
    end
    #1;
    chk("out_data", out_data, e_data);
    chk("out_valid", out_valid, e_vld);
    chk("tile_done", tile_done, e_done);
    chk("in_ready", in_ready, e_rdy);
    chk("busy", busy, e_busy);
    if (tile_done) begin
      dones.push_back(k);
      d_l7.push_back(out_data[63:56]);
      d_data.push_back(out_data);
      $display("tile_done cycle=%0d lane7=%0d", k, out_data[63:56]);
    end
    if (out_valid != 0 && prev_vld == 0) starts.push_back(k);
    if (log_en && out_valid != 0) ov_log.push_back(out_valid);
    prev_vld = out_valid;
  end

  // ---------------- stimulus ----------------
  logic [63:0] vecs [32];
  int          nrdy = 0;

  task automatic send(input int n, input int mode);
    int idx = 0;
    int cyc = 0;
    int guard = 0;
    bit want;
    while (idx < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (mode == 0)      want = 1;
      else if (mode == 1) want = (cyc % 3 == 0);
      else                want = ($urandom_range(0, 1) == 1);
      cyc++;
      if (want) begin
        in_valid = 1'b1;
        in_data  = vecs[idx];
        if (in_ready) idx++;
        else nrdy++;
      end else begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
      end
    end
    if (idx < n) chk("send_timeout", 64'(idx), 64'(n));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((busy || out_valid != 0 || tile_done) && g < 200);
    if (g >= 200) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic basic_vecs();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        vecs[r][j*DW +: DW] = 8'(r * 8 + j);
  endtask

  task automatic rand_vecs(input int n);
    for (int r = 0; r < n; r++) vecs[r] = {$urandom, $urandom};
  endtask

  task automatic clear_logs();
    dones.delete();
    starts.delete();
    d_l7.delete();
    d_data.delete();
    ov_log.delete();
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic tile
    basic_vecs();
    clear_logs();
    log_en = 1;
    send(8, 0);
    wait_idle();
    log_en = 0;
    chk("basic_ncycles", 64'(ov_log.size()), 64'd15);
    chk("basic_vld0", ov_log[0], 8'h01);
    chk("basic_vld1", ov_log[1], 8'h03);
    chk("basic_vld7", ov_log[7], 8'hFF);
    chk("basic_vld8", ov_log[8], 8'hFE);
    chk("basic_vld14", ov_log[14], 8'h80);
    chk("basic_ndone", 64'(dones.size()), 64'd1);
    chk("basic_done_l7", d_l7[0], 8'd63);
    chk("basic_done_data", d_data[0], 64'h3F00_0000_0000_0000);

    // gapped input, same data
    clear_logs();
    log_en = 1;
    send(8, 1);
    wait_idle();
    log_en = 0;
    chk("gap_ncycles", 64'(ov_log.size()), 64'd15);
    chk("gap_done_l7", d_l7[0], 8'd63);

    // back-to-back / hold-off: 16 vectors with in_valid held high
    rand_vecs(16);
    clear_logs();
    nrdy = 0;
    send(16, 0);
    wait_idle();
    chk("hold_notready", 64'(nrdy), 64'd15);
    chk("b2b_ndone", 64'(dones.size()), 64'd2);
    chk("b2b_gap", 64'(starts[1] - dones[0]), 64'd9);

    // mid-stream reset
    rand_vecs(8);
    clear_logs();
    send(8, 0);
    repeat (5) @(negedge clk);
    chk("mid_pre_valid", out_valid, 8'h1F);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_done", tile_done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_no_done", 64'(dones.size()), 64'd0);
    basic_vecs();
    send(8, 0);
    wait_idle();
    chk("mid_fresh_done", d_l7[0], 8'd63);

    // randomized valid pattern, four tiles
    rand_vecs(32);
    clear_logs();
    send(32, 2);
    wait_idle();
    chk("rand_ndone", 64'(dones.size()), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
